parity_100b: RTL and testbench



---
 rtl/parity_100b_pkg.sv | 10 +
 rtl/parity_100b_if.sv | 19 +
 rtl/parity_100b_xor_tree.sv | 43 ++++
 rtl/parity_100b.sv | 35 +++
 tb/tb_parity_100b.sv | 118 +++++++++++
 5 files changed

// File: rtl/parity_100b_pkg.sv
// ---------------------------------------------------------------------------
// parity_100b_pkg
// Shared constants for the parity leaf block of the codes/ECC datapath.
//   PARITY_WIDTH : data width, in bits, of the standard parity word.
// ---------------------------------------------------------------------------
package parity_100b_pkg;

  localparam int PARITY_WIDTH = 100;

endpackage : parity_100b_pkg

// File: rtl/parity_100b_if.sv
// ---------------------------------------------------------------------------
// parity_100b_if
// Bundles the data word and the parity bit it produces.
//   in_ : WIDTH-bit data word, driven by the producer (master)
//   out : parity bit (XOR of all in_ bits), driven by the parity block (slave)
// ---------------------------------------------------------------------------
interface parity_100b_if
  import parity_100b_pkg::*;
#(
  parameter int WIDTH = PARITY_WIDTH
);

  logic [WIDTH-1:0] in_;
  logic             out;

  modport master (output in_, input out);
  modport slave  (input in_, output out);

endinterface : parity_100b_if

// File: rtl/parity_100b_xor_tree.sv
// ---------------------------------------------------------------------------
// parity_xor_tree
// Balanced XOR reduction of a WIDTH-bit word.
//   i_data : WIDTH-bit input word
//   o_par  : XOR of all bits of i_data
//
// The tree is laid out as a heap: node n combines nodes 2n and 2n+1, the
// input bits occupy leaves WIDTH..2*WIDTH-1 and node 1 is the root. Each
// level therefore halves the number of live values; when a level holds an
// odd count, the unpaired value is carried up one level and pairs with a
// node there. The deepest leaf sits ceil(log2(WIDTH)) XOR levels below the
// root, which is 7 for a 100-bit word.
// ---------------------------------------------------------------------------
module parity_xor_tree
  import parity_100b_pkg::*;
#(
  parameter int WIDTH = PARITY_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_par
);

  // Index 0 is never used, so the array starts at 1 to keep the heap math plain.
  logic w_node [1:2*WIDTH-1];

  genvar g_leaf;
  generate
    for (g_leaf = 0; g_leaf < WIDTH; g_leaf++) begin : g_leaves
      assign w_node[WIDTH+g_leaf] = i_data[g_leaf];
    end
  endgenerate

  genvar g_int;
  generate
    for (g_int = 1; g_int < WIDTH; g_int++) begin : g_internal
      assign w_node[g_int] = w_node[2*g_int] ^ w_node[2*g_int+1];
    end
  endgenerate

  // For WIDTH == 1 the root is the single leaf and no XOR is built.
  assign o_par = w_node[1];

endmodule : parity_xor_tree

// File: rtl/parity_100b.sv
// ---------------------------------------------------------------------------
// parity_100b
// Combinational parity generator: bus.out is 1 when bus.in_ holds an odd
// number of ones. Zero-cycle latency; no state.
//   clk   : clock (present for the standard block interface, unused)
//   reset : synchronous active-high reset (no effect on the output)
//   bus   : parity_100b_if.slave -- in_ (data word), out (parity bit)
// ---------------------------------------------------------------------------
module parity_100b
  import parity_100b_pkg::*;
#(
  parameter int WIDTH = PARITY_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  parity_100b_if.slave   bus
);

  logic w_par;

  parity_xor_tree #(
    .WIDTH (WIDTH)
  ) u_tree (
    .i_data (bus.in_),
    .o_par  (w_par)
  );

  assign bus.out = w_par;

  // clk and reset exist only for interface uniformity; gathering them into a
  // signal named *unused* marks them as intentionally unconsumed.
  logic w_unused_ctl;
  assign w_unused_ctl = clk ^ reset;

endmodule : parity_100b

// File: tb/tb_parity_100b.sv
// ---------------------------------------------------------------------------
// tb_parity_100b
// Directed bench for parity_100b with hand-computed expected values plus a
// popcount-mod-2 reference for random words.
// ---------------------------------------------------------------------------
module tb_parity_100b;

  localparam int W = 100;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  parity_100b_if #(.WIDTH(W)) bus ();

  parity_100b #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Change the word shortly after a rising edge and check well before the next.
  task automatic apply(input logic [W-1:0] v);
    @(posedge clk);
    #2 bus.in_ = v;
    #2;
  endtask

  logic [15:0]  nib_par;
  logic [W-1:0] v;
  logic [127:0] rnd;
  logic         exp_bit;

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    bus.in_ = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_zero", bus.out, 1'b0);
    reset = 1'b0;

    // Parity of 0..15 written out by hand: 0110 1001 1001 0110, MSB = value 15.
    nib_par = 16'b0110_1001_1001_0110;
    for (int n = 0; n < 16; n++) begin
      v = '0;
      v[3:0] = n[3:0];
      apply(v);
      chk($sformatf("nibble_%0d", n), bus.out, nib_par[n]);
    end

    apply('0);
    chk("all_zero", bus.out, 1'b0);
    apply(100'ha_aaaa_aaaa_aaaa_aaaa_aaaa_aaaa);
    chk("alt_a", bus.out, 1'b0);
    apply(100'h5_5555_5555_5555_5555_5555_5555);
    chk("alt_5", bus.out, 1'b0);
    apply(100'hf_ffff_ffff_ffff_ffff_ffff_ffff);
    chk("all_ones", bus.out, 1'b0);

    for (int k = 0; k < W; k++) begin
      v = '0;
      v[k] = 1'b1;
      apply(v);
      chk($sformatf("walk1_%0d", k), bus.out, 1'b1);
    end

    for (int k = 0; k < W; k++) begin
      v = '1;
      v[k] = 1'b0;
      apply(v);
      chk($sformatf("walk0_%0d", k), bus.out, 1'b1);
    end

    v = '0;
    v[0]  = 1'b1;
    v[99] = 1'b1;
    apply(v);
    chk("pair_0_99", bus.out, 1'b0);

    for (int r = 0; r < 24; r++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      v = rnd[W-1:0];
      exp_bit = ($countones(v) % 2) == 1;
      apply(v);
      chk($sformatf("rand_%0d", r), bus.out, exp_bit);
    end

    // Reset must not disturb the output.
    @(posedge clk);
    #2 reset = 1'b1;
    bus.in_ = 100'h1;
    @(posedge clk);
    #2;
    chk("rst_hold", bus.out, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_release", bus.out, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_parity_100b
